clk_div_multi: RTL
==================

# clk_div_multi

Parametrised multi-channel clock divider for the stopwatch/timer datapath. It generates NCH independent square-wave outputs from the 100 MHz system clock, with a single-cycle tick enable per channel. Each channel's half-period is set by a parameter at reset and can be rewritten at run time. Channels can be frozen individually and phase-aligned together with a common sync strobe, so display-scan and timebase clocks come from one block.

## Interface
Parameters:
- NCH, 2, number of output channels (1..16)
- CW, 19, counter and half-period width in bits
- SEL_W, 1, width of cfg_sel; must satisfy 2^SEL_W >= NCH
- HALF_INIT, {19'd49999, 19'd499999}, packed reset half-periods; channel i at bits [i*CW +: CW]; defaults give ch0 = 100 Hz and ch1 = 1 kHz from 100 MHz

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- en  in  NCH  per-channel run enable; 0 freezes that channel
- sync  in  1  one-cycle strobe; restarts all channels in phase
- cfg_we  in  1  half-period write strobe
- cfg_sel  in  SEL_W  channel index for write
- cfg_half  in  CW  new half-period value
- clk_out  out  NCH  divided square waves
- tick  out  NCH  one-cycle pulse coinciding with each clk_out rising transition
- half_rd  out  NCH*CW  current half-period registers, packed like HALF_INIT

## Operation
- Per channel i: registers half[i], cnt[i] (CW bits), clk_out[i], tick[i].
- Reset (reset==0 at a clk edge): half[i] <= HALF_INIT slice, cnt <= 0, clk_out <= 0, tick <= 0. Reset has highest priority.
- Priority per channel, highest first: reset, cfg write to this channel, sync, en==0, normal count.
- Normal count (en[i]==1): if cnt==half, then clk_out toggles and cnt <= 0; otherwise cnt <= cnt+1. tick <= 1 only on the edge where clk_out goes 0->1; otherwise tick <= 0.
- Output period is 2*(half+1) clk cycles at 50% duty. half==0 gives clk/2. Maximum half is 2^CW-1. Counter arithmetic never exceeds half, so there is no wrap beyond half.
- en[i]==0: cnt and clk_out hold and tick <= 0. Counting resumes from the held cnt when en returns to 1.
- sync==1: all channels get cnt <= 0, clk_out <= 0, tick <= 0, regardless of en.
- cfg_we==1 with cfg_sel < NCH: half[cfg_sel] <= cfg_half, and that channel restarts (cnt <= 0, clk_out <= 0, tick <= 0). The write beats a same-cycle terminal count. With cfg_sel >= NCH, the write is ignored.
- A write coinciding with sync: both take effect. Unselected channels see sync only.
- Reset asserted mid-period aborts the period; the channel restarts from cnt 0 after release.

## Timing
- All outputs are registered, with no combinational paths from inputs to outputs.
- After reset release, sync, or a write, the first clk_out rising edge occurs at the (half+1)th clk edge. tick is high during the same cycle that clk_out first reads 1.
- Falling edge follows after a further half+1 edges.
- half_rd reflects a write on the cycle after cfg_we.

## Configuration
- CLKDIV_TICK_EN
- Defined: tick is generated as described above.
- Undefined: tick is tied to 0, and the tick registers and their logic are removed. clk_out behaviour is unchanged.

## Test plan
- CW=4, NCH=2, HALF_INIT={4'd1, 4'd3}: release reset -> ch0 rises after edge 4 with period 8; ch1 rises after edge 2 with period 4. tick is high for 1 cycle at each rise.
- At cycle 10, write cfg_sel=0, cfg_half=0 -> ch0 restarts low, rises 1 edge later, then toggles every cycle. half_rd[3:0]==0 next cycle.
- Drop en[1] for 5 cycles mid-period -> clk_out[1] and cnt hold, tick[1]==0, and the period stretches by exactly 5 cycles. ch0 is unaffected.
- Pulse sync at arbitrary phase -> both outputs go 0 next cycle and rise after 4 and 2 edges respectively. Sync applied with en=0 still clears.
- Write with cfg_sel=1 on the exact cycle cnt[1]==half[1] -> no toggle; the channel restarts with the new value. Write with cfg_sel=3 (NCH=2) -> no state change.
- Assert reset mid-period -> all outputs 0 and half restored to HALF_INIT. With CLKDIV_TICK_EN undefined, tick stays 0 throughout.

Source files
------------

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH-channel square-wave divider with per-channel run enable,
// run-time half-period writes and a common phase-align strobe. Define CLKDIV_TICK_EN for tick outputs.
module clk_div_multi #(
    parameter int unsigned       NCH       = 2,
    parameter int unsigned       CW        = 19,
    parameter int unsigned       SEL_W     = 1,
    parameter logic [NCH*CW-1:0] HALF_INIT = {19'd49999, 19'd499999}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [CW-1:0]     cfg_half,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    tick,
    output logic [NCH*CW-1:0] half_rd
);

    logic [CW-1:0]  half_q [NCH];
    logic [CW-1:0]  half_d [NCH];
    logic [CW-1:0]  cnt_q  [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [NCH-1:0] clk_q;
    logic [NCH-1:0] clk_d;
    logic [NCH-1:0] term;
    logic [NCH-1:0] wr_hit;
    logic [31:0]    sel_ext;

    assign sel_ext = 32'(cfg_sel);

    // A select >= NCH matches no channel, so such writes are dropped here.
    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr_hit[i] = cfg_we && (sel_ext == i);
        end
    end

    always_comb begin
        term = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            term[i] = (cnt_q[i] == half_q[i]);
        end
    end

    always_comb begin
        clk_d = clk_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];
            if (wr_hit[i]) begin
                half_d[i] = cfg_half;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
            end else if (sync) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (en[i]) begin
                if (term[i]) begin
                    cnt_d[i] = '0;
                    clk_d[i] = ~clk_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                half_q[i] <= HALF_INIT[i*CW +: CW];
                cnt_q[i]  <= '0;
            end
            clk_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            clk_q <= clk_d;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] tick_d;

    // Tick fires only on a counting edge that takes the output from 0 to 1.
    always_comb begin
        tick_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            tick_d[i] = !wr_hit[i] && !sync && en[i] && term[i] && !clk_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    assign tick = '0;
`endif

    assign clk_out = clk_q;

    always_comb begin
        half_rd = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            half_rd[i*CW +: CW] = half_q[i];
        end
    end

endmodule
